// File: rtl/pipe_mw_if.sv
// Memory->Writeback boundary bus: M-stage bundle in, W-stage register-file port out.
// Master drives the M-stage side; slave is the pipeline register.
interface pipe_mw_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5
);
    logic                  ValidM;
    logic                  RegWriteM;
    logic [1:0]            ResultSrcM;
    logic [DATA_WIDTH-1:0] ALUResultM;
    logic [DATA_WIDTH-1:0] ReadDataM;
    logic [REG_AW-1:0]     RdM;
    logic [DATA_WIDTH-1:0] PCPlus4M;

    logic                  ValidW;
    logic                  RegWriteW;
    logic [REG_AW-1:0]     RdW;
    logic [DATA_WIDTH-1:0] ResultW;
    logic [1:0]            ResultSrcW;

    modport master (
        output ValidM, RegWriteM, ResultSrcM, ALUResultM,
        output ReadDataM, RdM, PCPlus4M,
        input  ValidW, RegWriteW, RdW, ResultW, ResultSrcW
    );

    modport slave (
        input  ValidM, RegWriteM, ResultSrcM, ALUResultM,
        input  ReadDataM, RdM, PCPlus4M,
        output ValidW, RegWriteW, RdW, ResultW, ResultSrcW
    );
endinterface

// File: rtl/pipe_mw.sv
// M->W pipeline register with stall/flush and the write-back result mux.
// Optional RETIRE_CNT_EN adds a 64-bit retired-instruction counter output.
module pipe_mw #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        flush,
`ifdef RETIRE_CNT_EN
    output logic [63:0] RetireCnt,
`endif
    pipe_mw_if.slave    bus
);
    logic                  valid_q, valid_d;
    logic                  regwrite_q, regwrite_d;
    logic [1:0]            resultsrc_q, resultsrc_d;
    logic [DATA_WIDTH-1:0] alu_q, alu_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [REG_AW-1:0]     rd_q, rd_d;
    logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
`ifdef RETIRE_CNT_EN
    logic [63:0]           retire_q, retire_d;
`endif

    always_comb begin
        valid_d     = valid_q;
        regwrite_d  = regwrite_q;
        resultsrc_d = resultsrc_q;
        alu_d       = alu_q;
        rdata_d     = rdata_q;
        rd_d        = rd_q;
        pc4_d       = pc4_q;
        // Flush beats stall; data fields are simply held on a bubble.
        if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
        end else if (en) begin
            valid_d     = bus.ValidM;
            regwrite_d  = bus.RegWriteM;
            resultsrc_d = bus.ResultSrcM;
            alu_d       = bus.ALUResultM;
            rdata_d     = bus.ReadDataM;
            rd_d        = bus.RdM;
            pc4_d       = bus.PCPlus4M;
        end
`ifdef RETIRE_CNT_EN
        retire_d = retire_q;
        if (valid_q && (en || flush))
            retire_d = retire_q + 64'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= 2'b00;
            alu_q       <= '0;
            rdata_q     <= '0;
            rd_q        <= '0;
            pc4_q       <= '0;
`ifdef RETIRE_CNT_EN
            retire_q    <= 64'd0;
`endif
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            alu_q       <= alu_d;
            rdata_q     <= rdata_d;
            rd_q        <= rd_d;
            pc4_q       <= pc4_d;
`ifdef RETIRE_CNT_EN
            retire_q    <= retire_d;
`endif
        end
    end

    always_comb begin
        bus.ResultW = '0;
        unique case (resultsrc_q)
            2'b00:   bus.ResultW = alu_q;
            2'b01:   bus.ResultW = rdata_q;
            2'b10:   bus.ResultW = pc4_q;
            default: bus.ResultW = '0;
        endcase
    end

    // x0 is hardwired, so a write there is never presented.
    assign bus.ValidW     = valid_q;
    assign bus.RegWriteW  = valid_q & regwrite_q & (rd_q != '0);
    assign bus.RdW        = rd_q;
    assign bus.ResultSrcW = resultsrc_q;
`ifdef RETIRE_CNT_EN
    assign RetireCnt      = retire_q;
`endif
endmodule

// File: tb/tb_pipe_mw.sv
// Bench for pipe_mw: directed vector table, a reset-in-flight sequence,
// then random traffic against a slot-level reference model.
module tb_pipe_mw;
    logic clk = 1'b0;
    logic rst, en, flush;
`ifdef RETIRE_CNT_EN
    logic [63:0] RetireCnt;
`endif

    pipe_mw_if #(.DATA_WIDTH(32), .REG_AW(5)) bus ();

    pipe_mw #(.DATA_WIDTH(32), .REG_AW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
`ifdef RETIRE_CNT_EN
        .RetireCnt (RetireCnt),
`endif
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic f,
                         input logic vm, input logic wm,
                         input logic [1:0] src, input logic [31:0] alu,
                         input logic [31:0] rdat, input logic [4:0] rd,
                         input logic [31:0] pc4);
        rst = r; en = e; flush = f;
        bus.ValidM = vm; bus.RegWriteM = wm; bus.ResultSrcM = src;
        bus.ALUResultM = alu; bus.ReadDataM = rdat;
        bus.RdM = rd; bus.PCPlus4M = pc4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r, e, f, vm, wm;
        logic [1:0]  src;
        logic [31:0] alu, rdat;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        ev, ew;
        logic [4:0]  erd;
        logic [31:0] eres;
        logic [1:0]  esrc;
        logic [63:0] ecnt;
    } vec_t;

    vec_t vecs[13];

    // Reference slot: what instruction sits in W, described abstractly.
    typedef struct {
        logic        valid, we;
        logic [1:0]  src;
        logic [31:0] alu, rdat, pc4;
        logic [4:0]  rd;
    } slot_t;

    function automatic logic [31:0] result_of(input slot_t s);
        if (s.src == 2'd0) return s.alu;
        if (s.src == 2'd1) return s.rdat;
        if (s.src == 2'd2) return s.pc4;
        return 32'd0;
    endfunction

    task automatic check_cnt(input string name, input logic [63:0] exp);
`ifdef RETIRE_CNT_EN
        check(name, RetireCnt, exp);
`else
        if (exp === 64'hx) check(name, 64'd0, 64'd1);
`endif
    endtask

    initial begin
        slot_t m;
        logic [63:0] mcnt;
        logic [31:0] r1, r2, r3;

        //         r  e  f  vm wm src alu        rdat          rd pc4
        //         ev ew erd eres        esrc cnt
        vecs[0]  = '{1,1,0,1,1,2'd1,32'h1234,32'h5678,5'd9,32'h9abc,
                     0,0,5'd0,32'h0,2'd0,64'd0};
        vecs[1]  = '{1,1,1,1,1,2'd2,32'h4321,32'h8765,5'd3,32'hcba9,
                     0,0,5'd0,32'h0,2'd0,64'd0};
        vecs[2]  = '{0,1,0,1,1,2'd1,32'h11,32'hDEADBEEF,5'd5,32'h22,
                     1,1,5'd5,32'hDEADBEEF,2'd1,64'd0};
        vecs[3]  = '{0,1,0,1,1,2'd2,32'h33,32'h44,5'd7,32'h104,
                     1,1,5'd7,32'h104,2'd2,64'd1};
        vecs[4]  = '{0,0,0,1,1,2'd0,32'h99,32'h98,5'd9,32'h97,
                     1,1,5'd7,32'h104,2'd2,64'd1};
        vecs[5]  = '{0,0,0,0,0,2'd1,32'h96,32'h95,5'd2,32'h94,
                     1,1,5'd7,32'h104,2'd2,64'd1};
        vecs[6]  = '{0,0,0,1,1,2'd3,32'h93,32'h92,5'd1,32'h91,
                     1,1,5'd7,32'h104,2'd2,64'd1};
        vecs[7]  = '{0,0,1,1,1,2'd0,32'h90,32'h8f,5'd8,32'h8e,
                     0,0,5'd7,32'h104,2'd2,64'd2};
        vecs[8]  = '{0,1,0,1,1,2'd0,32'h55,32'h56,5'd0,32'h57,
                     1,0,5'd0,32'h55,2'd0,64'd2};
        vecs[9]  = '{0,1,0,1,1,2'd3,32'h77,32'h78,5'd3,32'h79,
                     1,1,5'd3,32'h0,2'd3,64'd3};
        vecs[10] = '{0,1,0,0,1,2'd0,32'h66,32'h67,5'd4,32'h68,
                     0,0,5'd4,32'h66,2'd0,64'd4};
        vecs[11] = '{0,1,1,1,1,2'd0,32'hAB,32'hAC,5'd6,32'hAD,
                     0,0,5'd4,32'h66,2'd0,64'd4};
        vecs[12] = '{1,0,1,1,1,2'd1,32'hEE,32'hEF,5'd7,32'hF0,
                     0,0,5'd0,32'h0,2'd0,64'd0};

        drive(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
        #2;
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].r, vecs[i].e, vecs[i].f, vecs[i].vm, vecs[i].wm,
                  vecs[i].src, vecs[i].alu, vecs[i].rdat, vecs[i].rd,
                  vecs[i].pc4);
            step();
            check($sformatf("vec%0d.valid", i), 64'(bus.ValidW), 64'(vecs[i].ev));
            check($sformatf("vec%0d.we", i), 64'(bus.RegWriteW), 64'(vecs[i].ew));
            check($sformatf("vec%0d.rd", i), 64'(bus.RdW), 64'(vecs[i].erd));
            check($sformatf("vec%0d.res", i), 64'(bus.ResultW), 64'(vecs[i].eres));
            check($sformatf("vec%0d.src", i), 64'(bus.ResultSrcW), 64'(vecs[i].esrc));
            check_cnt($sformatf("vec%0d.cnt", i), vecs[i].ecnt);
        end

        // Back-to-back valid instructions, reset lands on the third.
        drive(0, 1, 0, 1, 1, 2'd0, 32'h10, 0, 5'd1, 0);
        step();
        check("b2b1.res", 64'(bus.ResultW), 64'h10);
        check("b2b1.we", 64'(bus.RegWriteW), 64'd1);
        drive(0, 1, 0, 1, 1, 2'd0, 32'h20, 0, 5'd2, 0);
        step();
        check("b2b2.res", 64'(bus.ResultW), 64'h20);
        check("b2b2.rd", 64'(bus.RdW), 64'd2);
        check_cnt("b2b2.cnt", 64'd1);
        drive(1, 1, 0, 1, 1, 2'd2, 32'h30, 32'h31, 5'd3, 32'h32);
        step();
        check("b2b3.valid", 64'(bus.ValidW), 64'd0);
        check("b2b3.we", 64'(bus.RegWriteW), 64'd0);
        check("b2b3.rd", 64'(bus.RdW), 64'd0);
        check("b2b3.res", 64'(bus.ResultW), 64'd0);
        check("b2b3.src", 64'(bus.ResultSrcW), 64'd0);
        check_cnt("b2b3.cnt", 64'd0);

        // Random traffic; DUT and model both start from reset here.
        m = '{valid: 1'b0, we: 1'b0, src: 2'd0, alu: 32'd0,
              rdat: 32'd0, pc4: 32'd0, rd: 5'd0};
        mcnt = 64'd0;
        for (int c = 0; c < 3000; c++) begin
            r1 = $urandom; r2 = $urandom; r3 = $urandom;
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
                  2'($urandom), r1, r2,
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), r3);
            if (rst) begin
                m = '{valid: 1'b0, we: 1'b0, src: 2'd0, alu: 32'd0,
                      rdat: 32'd0, pc4: 32'd0, rd: 5'd0};
                mcnt = 64'd0;
            end else begin
                if (m.valid && (en || flush)) mcnt = mcnt + 64'd1;
                if (flush) begin
                    m.valid = 1'b0;
                    m.we    = 1'b0;
                end else if (en) begin
                    m = '{valid: bus.ValidM, we: bus.RegWriteM,
                          src: bus.ResultSrcM, alu: bus.ALUResultM,
                          rdat: bus.ReadDataM, pc4: bus.PCPlus4M,
                          rd: bus.RdM};
                end
            end
            step();
            check("rnd.valid", 64'(bus.ValidW), 64'(m.valid));
            check("rnd.we", 64'(bus.RegWriteW),
                  64'(m.valid && m.we && m.rd != 5'd0));
            check("rnd.rd", 64'(bus.RdW), 64'(m.rd));
            check("rnd.res", 64'(bus.ResultW), 64'(result_of(m)));
            check("rnd.src", 64'(bus.ResultSrcW), 64'(m.src));
            check_cnt("rnd.cnt", mcnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
